// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings, slot state type and op legality check for the ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Response slot occupancy; FULL is exactly rsp_valid=1.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared ALU arbiter and its consumer.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester, rsp_ready from the consumer.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREQ = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ*3-1:0]    req_op;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_zero;
    logic                 rsp_err;

    // Requesters plus consumer side.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin picker: first valid request after last_grant, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own readiness.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    // Scan offsets 1..NREQ from last_grant so the previous winner is checked last.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one RV32I ALU between NREQ requesters with round-robin grant and a one-entry registered response slot.
// Latency: one cycle from accept edge to rsp_valid with data.
// Backpressure: a full slot with rsp_ready=0 drops all req_ready; drain and refill can happen in the same cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREQ = 2
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [IDW-1:0]  last_grant;

    logic            slot_free;
    logic            accept;

    logic [XLEN-1:0] win_a;
    logic [XLEN-1:0] win_b;
    logic [2:0]      win_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_err;

    slot_state_t     state_q;
    slot_state_t     state_d;
    logic            slot_full;

    logic [IDW-1:0]  rsp_id_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_zero_q;
    logic            rsp_err_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign grant_any = |grant;
    assign slot_free = !slot_full || bus.rsp_ready;
    assign accept    = grant_any && slot_free && !reset;

    // Ready only toward the current winner, and never during reset.
    assign bus.req_ready = accept ? grant : '0;

    // One-hot AND-OR mux of the winner's operands into the single ALU.
    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_a  = bus.req_a[i*XLEN +: XLEN];
                win_b  = bus.req_b[i*XLEN +: XLEN];
                win_op = bus.req_op[i*3 +: 3];
            end
        end
    end

    // Shared ALU datapath; illegal ops produce zero and raise the error flag.
    always_comb begin
        alu_result = '0;
        case (win_op)
            ALU_ADD: alu_result = win_a + win_b;
            ALU_SUB: alu_result = win_a + ~win_b + XLEN'(1);
            ALU_AND: alu_result = win_a & win_b;
            ALU_OR:  alu_result = win_a | win_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(win_a) < $signed(win_b))};
            default: alu_result = '0;
        endcase
        alu_err = !is_legal_op(win_op);
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: fill on accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (bus.rsp_ready && !accept) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Slot outputs decoded from state.
    always_comb begin
        slot_full = (state_q == SLOT_FULL);
    end

    // Response data fields load only on accept and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (accept) begin
            rsp_id_q     <= grant_idx;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= (alu_result == '0);
            rsp_err_q    <= alu_err;
        end
    end

    // Round-robin pointer advances only when a request is actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDW'(NREQ - 1);
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end

    assign bus.rsp_valid  = slot_full;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter against a behavioural slot/arbiter model.
// Latency: model expects response one edge after accept.
// Backpressure: random rsp_ready stalls exercise the hold path.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic clk;
    logic reset;

    alu_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) ifc ();

    alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic        m_valid;
    int          m_id;
    logic [31:0] m_res;
    logic        m_zero;
    logic        m_err;
    int          m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] r, output logic e);
        e = 1'b0;
        r = 32'd0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (ifc.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        ifc.req_valid[i]         = v;
        ifc.req_a[i*XLEN +: XLEN] = a;
        ifc.req_b[i*XLEN +: XLEN] = b;
        ifc.req_op[i*3 +: 3]      = op;
    endtask

    // One clock of stimulus: check ready before the edge, advance the model, check the slot after.
    task automatic step(input string tag, output logic [NREQ-1:0] acc);
        int          w;
        logic        free;
        logic [31:0] r;
        logic        e;
        #1;
        free = !m_valid || ifc.rsp_ready;
        w    = pick();
        acc  = '0;
        if (!reset && free && w >= 0) acc[w] = 1'b1;
        chk({tag, ".rdy"}, 64'(ifc.req_ready), 64'(acc));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_id = 0; m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_last = NREQ - 1;
        end else if (acc != '0) begin
            alu_ref(ifc.req_a[w*XLEN +: XLEN], ifc.req_b[w*XLEN +: XLEN], ifc.req_op[w*3 +: 3], r, e);
            m_valid = 1'b1; m_id = w; m_res = r; m_zero = (r == 32'd0); m_err = e; m_last = w;
        end else if (m_valid && ifc.rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".vld"},  64'(ifc.rsp_valid),  64'(m_valid));
        chk({tag, ".id"},   64'(ifc.rsp_id),     64'(m_id));
        chk({tag, ".res"},  64'(ifc.rsp_result), 64'(m_res));
        chk({tag, ".zero"}, 64'(ifc.rsp_zero),   64'(m_zero));
        chk({tag, ".err"},  64'(ifc.rsp_err),    64'(m_err));
    endtask

    function automatic logic [31:0] rand_opnd();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    logic [NREQ-1:0] acc;
    logic [31:0]     held;

    initial begin
        m_valid = 1'b0; m_id = 0; m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_last = NREQ - 1;
        reset = 1'b1;
        ifc.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i + 10), 32'd1, 3'd0);

        // Reset held two cycles with every requester valid
        step("rst0", acc);
        step("rst1", acc);
        reset = 1'b0;
        step("first", acc);
        chk("first.id0", 64'(ifc.rsp_id), 64'd0);
        chk("first.res", 64'(ifc.rsp_result), 64'd11);

        // Single request from requester 1: 7 - 9
        set_req(0, 1'b0, '0, '0, 3'd0);
        set_req(1, 1'b1, 32'd7, 32'd9, 3'b001);
        step("single", acc);
        set_req(1, 1'b0, '0, '0, 3'd0);
        chk("single.id",   64'(ifc.rsp_id),     64'd1);
        chk("single.res",  64'(ifc.rsp_result), 64'hFFFF_FFFE);
        chk("single.zero", 64'(ifc.rsp_zero),   64'd0);
        step("drain", acc);

        // slt signed and zero flag
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
        step("slt", acc);
        chk("slt.res", 64'(ifc.rsp_result), 64'd1);
        set_req(0, 1'b1, 32'd5, 32'd5, 3'b001);
        step("zero", acc);
        chk("zero.res",  64'(ifc.rsp_result), 64'd0);
        chk("zero.flag", 64'(ifc.rsp_zero),   64'd1);

        // Illegal op then legal op clears err
        set_req(0, 1'b1, 32'd3, 32'd4, 3'b110);
        step("illegal", acc);
        chk("illegal.res", 64'(ifc.rsp_result), 64'd0);
        chk("illegal.err", 64'(ifc.rsp_err),    64'd1);
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b000);
        step("legal", acc);
        chk("legal.err", 64'(ifc.rsp_err),    64'd0);
        chk("legal.res", 64'(ifc.rsp_result), 64'd3);
        set_req(0, 1'b0, '0, '0, 3'd0);

        // Round-robin fairness from a fresh reset
        reset = 1'b1;
        step("rrrst", acc);
        reset = 1'b0;
        set_req(0, 1'b1, 32'd100, 32'd1, 3'd0);
        set_req(1, 1'b1, 32'd200, 32'd2, 3'd0);
        for (int k = 0; k < 6; k++) begin
            step("rr", acc);
            chk("rr.order", 64'(ifc.rsp_id), 64'(k % 2));
        end

        // Backpressure: slot full, consumer stalled three cycles
        ifc.rsp_ready = 1'b0;
        held = ifc.rsp_result;
        for (int k = 0; k < 3; k++) begin
            step("stall", acc);
            chk("stall.rdy0", 64'(acc), 64'd0);
            chk("stall.hold", 64'(ifc.rsp_result), 64'(held));
        end
        ifc.rsp_ready = 1'b1;
        step("unstall", acc);
        chk("unstall.vld", 64'(ifc.rsp_valid), 64'd1);
        chk("unstall.id",  64'(ifc.rsp_id),    64'd0);

        // Randomized traffic, requests held until taken
        for (int c = 0; c < 400; c++) begin
            ifc.rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!ifc.req_valid[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
            end
            step("rand", acc);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) ifc.req_valid[i] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
